// File: rtl/board_run_ctrl_if.sv
// board_run_ctrl_if: board/CPU-side signals of the run controller
// stall, step, halt_req : board switch, push-button and CPU halt request into the controller
// cpu_ena, state, cycle_cnt, step_done : controller outputs
interface board_run_ctrl_if #(parameter int CNT_W = 32);
  logic stall;
  logic step;
  logic halt_req;
  logic cpu_ena;
  logic [1:0] state;
  logic [CNT_W-1:0] cycle_cnt;
  logic step_done;
  modport master(output stall, step, halt_req, input cpu_ena, state, cycle_cnt, step_done);
  modport slave(input stall, step, halt_req, output cpu_ena, state, cycle_cnt, step_done);
endinterface

// File: rtl/board_run_ctrl.sv
// board_run_ctrl: run/pause/single-step/halt control of a CPU clock enable
// clk, rst : system clock, asynchronous active-high reset
// bus      : stall/step (raw async), halt_req in; cpu_ena, state, cycle_cnt, step_done out
module board_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  board_run_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] RUN = 2'b00, PAUSE = 2'b01, STEP = 2'b10, HALT = 2'b11;
  logic [1:0] s0, s1, db;
  logic [CW-1:0] cnt [2];
  logic step_q;
  logic step_pulse;
  logic [1:0] st, nxt;
  logic ena;
  logic [CNT_W-1:0] cycles;
  logic done;
  // bit 0 = stall, bit 1 = step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= {bus.step, bus.stall};
      s1 <= s0;
    end
  // a level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (s1[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          db[i] <= s1[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) step_q <= 1'b0;
    else step_q <= db[1];
  assign step_pulse = db[1] & ~step_q;
  assign ena = (st == RUN) || (st == STEP);
  // halt_req only matters in the two enabled states; step_pulse only in PAUSE
  always_comb
    nxt = st == RUN   ? (bus.halt_req ? HALT : (db[0] ? PAUSE : RUN)) :
          st == PAUSE ? (!db[0] ? RUN : (step_pulse ? STEP : PAUSE)) :
          st == STEP  ? (bus.halt_req ? HALT : PAUSE) : HALT;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= RUN;
      cycles <= '0;
      done <= 1'b0;
    end else begin
      st <= nxt;
      cycles <= cycles + CNT_W'(ena);
      done <= st == STEP;
    end
  assign bus.state = st;
  assign bus.cpu_ena = ena;
  assign bus.cycle_cnt = cycles;
  assign bus.step_done = done;
endmodule

// File: tb/tb_board_run_ctrl.sv
// tb_board_run_ctrl: scoreboard bench for board_run_ctrl against a window-based reference model
module tb_board_run_ctrl;
  localparam int D = 4;
  localparam logic [1:0] RUN = 2'b00, PAUSE = 2'b01, STEP = 2'b10, HALT = 2'b11;
  typedef struct {
    logic [1:0] st;
    logic ena;
    logic [31:0] cnt;
    logic done;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0, step = 1'b0, halt_req = 1'b0;
  int checks = 0, failures = 0;
  exp_t q[$];
  board_run_ctrl_if #(.CNT_W(32)) b32();
  board_run_ctrl_if #(.CNT_W(4)) b4();
  assign b32.stall = stall;
  assign b32.step = step;
  assign b32.halt_req = halt_req;
  assign b4.stall = stall;
  assign b4.step = step;
  assign b4.halt_req = halt_req;
  board_run_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  board_run_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  always #5 clk = ~clk;
  // reference model: a level is accepted once the last D synchronized samples all disagree with it
  logic [1:0] m_st;
  logic [31:0] m_cnt;
  logic m_done, m_dbs, m_dbp, m_prevp;
  bit hs[$], hp[$];
  task automatic model_reset();
    m_st = RUN;
    m_cnt = 0;
    m_done = 0;
    m_dbs = 0;
    m_dbp = 0;
    m_prevp = 0;
    hs.delete();
    hp.delete();
    for (int i = 0; i < D + 1; i++) begin
      hs.push_back(1'b0);
      hp.push_back(1'b0);
    end
  endtask
  task automatic model_edge();
    logic pulse, fs, fp;
    logic [1:0] ns;
    pulse = m_dbp & ~m_prevp;
    case (m_st)
      RUN: ns = halt_req ? HALT : (m_dbs ? PAUSE : RUN);
      PAUSE: ns = !m_dbs ? RUN : (pulse ? STEP : PAUSE);
      STEP: ns = halt_req ? HALT : PAUSE;
      default: ns = HALT;
    endcase
    m_done = (m_st == STEP);
    if (m_st == RUN || m_st == STEP) m_cnt = m_cnt + 1;
    m_st = ns;
    m_prevp = m_dbp;
    hs.push_back(stall);
    hp.push_back(step);
    fs = 1;
    fp = 1;
    for (int i = 0; i < D; i++) begin
      if (hs[i] == m_dbs) fs = 0;
      if (hp[i] == m_dbp) fp = 0;
    end
    if (fs) m_dbs = ~m_dbs;
    if (fp) m_dbp = ~m_dbp;
    void'(hs.pop_front());
    void'(hp.pop_front());
  endtask
  task automatic cyc(input logic s, input logic p, input logic h, input logic r, input logic kill_in_step = 1'b0);
    stall = s;
    step = p;
    halt_req = h;
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    rst = r | (kill_in_step && m_st == STEP);
    if (rst) model_reset();
    q.push_back('{m_st, (m_st == RUN || m_st == STEP), m_cnt, m_done});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", {30'd0, b32.state}, {30'd0, e.st});
      chk("cpu_ena", {31'd0, b32.cpu_ena}, {31'd0, e.ena});
      chk("cycle_cnt", b32.cycle_cnt, e.cnt);
      chk("cycle_cnt_w4", {28'd0, b4.cycle_cnt}, {28'd0, e.cnt[3:0]});
      chk("step_done", {31'd0, b32.step_done}, {31'd0, e.done});
      chk("state_w4", {30'd0, b4.state}, {30'd0, e.st});
    end
  initial begin
    bit hit;
    logic rs, rp, rr;
    model_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc(1, 1, 0, 0, 1'b1);
      hit = rst;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL step_reached: got no STEP within 40 cycles expected STEP");
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 0; i < 20; i++) cyc(i[3], i[2], 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    rs = 0;
    rp = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 19) == 0) rs = ~rs;
      if ($urandom_range(0, 7) == 0) rp = ~rp;
      rr = ($urandom_range(0, 399) == 0);
      cyc(rs, rp, 1'($urandom_range(0, 499) == 0), rr);
    end
    cyc(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
